// File: rtl/store_trace_tx.sv
// Store-trace transmitter: queues CPU stores in a first-word fall-through FIFO and appends an end token.
// Optional STALL_ON_FULL_EN: a full FIFO stalls the CPU instead of dropping stores.
module store_trace_tx #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] pc_finished,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  input  logic        retire,
  output logic        cpu_hold,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_addr,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic        done,
  output logic        overflow,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  localparam int AW = $clog2(DEPTH);

  // state | meaning
  // RUN   | CPU running, stores are queued
  // DRAIN | program finished, emptying the FIFO
  // END   | end token presented on tx_*
  // DONE  | trace complete, held until reset
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_END, S_DONE} state_t;

  state_t state, state_nx;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          finish, full, empty;
  logic          push_try, push, pop, lost;

  assign finish = (pc == pc_finished);
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);

`ifdef STALL_ON_FULL_EN
  assign cpu_hold = (state != S_RUN) | finish | full;
`else
  assign cpu_hold = (state != S_RUN) | finish;
`endif

  assign push_try = (state == S_RUN) & memwrite & ~cpu_hold;
  assign pop      = tx_valid & tx_ready & ~tx_last;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push     = push_try & (~full | pop);
`ifdef STALL_ON_FULL_EN
  assign lost     = 1'b0;
`else
  assign lost     = push_try & full & ~pop;
`endif

  assign done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_addr  = '0;
    tx_data  = '0;
    case (state)
      S_RUN: begin
        if (!empty) begin
          tx_valid = 1'b1;
          {tx_addr, tx_data} = mem[rd_ptr];
        end
        if (finish) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (!empty) begin
          tx_valid = 1'b1;
          {tx_addr, tx_data} = mem[rd_ptr];
        end else begin
          state_nx = S_END;
        end
      end
      S_END: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_addr  = pc_finished;
        tx_data  = cycle_count;
        if (tx_ready) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= {aluout, writedata};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (lost) overflow <= 1'b1;
      if (state == S_RUN && !finish) cycle_count <= cycle_count + 1'b1;
      if (state == S_RUN && retire && !cpu_hold) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_store_trace_tx.sv
// Directed bench for store_trace_tx: vector table for the basic trace, hand sequences for full,
// drain, counter and reset corners. Expectations follow STALL_ON_FULL_EN when it is defined.
module tb_store_trace_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, pc_finished, aluout, writedata;
  logic        memwrite, retire, tx_ready;
  logic        cpu_hold, tx_valid, tx_last, done, overflow;
  logic [31:0] tx_addr, tx_data, cycle_count, instr_count;

  always #5 clk = ~clk;

  store_trace_tx #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_finished(pc_finished),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .retire(retire),
    .cpu_hold(cpu_hold), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_addr(tx_addr), .tx_data(tx_data), .tx_last(tx_last), .done(done),
    .overflow(overflow), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        e_valid;
    logic        e_last;
    logic        e_hold;
    logic        e_done;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [9];
  int checks = 0;
  int errors = 0;

`ifdef STALL_ON_FULL_EN
  localparam logic HOLD_WHEN_FULL = 1'b1;
  localparam int   EXP_DELIVERED  = 10;
  localparam logic EXP_OVERFLOW   = 1'b0;
`else
  localparam logic HOLD_WHEN_FULL = 1'b0;
  localparam int   EXP_DELIVERED  = 8;
  localparam logic EXP_OVERFLOW   = 1'b1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0; memwrite = 1'b0; retire = 1'b0; tx_ready = 1'b0;
    pc = 32'h0; aluout = 32'h0; writedata = 32'h0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic vec_t mk(input logic [31:0] p, input logic mw, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy, input logic ev,
                              input logic el, input logic eh, input logic ed,
                              input logic [31:0] ea, input logic [31:0] edt);
    vec_t v;
    v.pc = p; v.mw = mw; v.addr = a; v.data = d; v.rdy = rdy;
    v.e_valid = ev; v.e_last = el; v.e_hold = eh; v.e_done = ed;
    v.e_addr = ea; v.e_data = edt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, got, pops;
    logic was_stalled;
    logic [31:0] held;

    pc_finished = 32'h3C;
    tbl[0] = mk(32'h0,  1'b1, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
    tbl[1] = mk(32'h0,  1'b1, 32'h4, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h5);
    tbl[2] = mk(32'h0,  1'b1, 32'h8, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4,  32'h7);
    tbl[3] = mk(32'h0,  1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8,  32'hC);
    tbl[4] = mk(32'h0,  1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0);
    tbl[5] = mk(32'h3C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0);
    tbl[6] = mk(32'h3C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0);
    tbl[7] = mk(32'h3C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3C, 32'h5);
    tbl[8] = mk(32'h3C, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h0);

    // reset state, checked while reset is still low
    reset = 1'b0; memwrite = 1'b0; retire = 1'b0; tx_ready = 1'b0;
    pc = 32'h0; aluout = 32'h0; writedata = 32'h0;
    tick();
    #1;
    chk("rst valid", 32'(tx_valid), 32'd0);
    chk("rst last", 32'(tx_last), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst addr", tx_addr, 32'h0);
    chk("rst data", tx_data, 32'h0);
    chk("rst cycles", cycle_count, 32'd0);
    chk("rst instrs", instr_count, 32'd0);

    // three stores then finish, via the vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pc = tbl[i].pc; memwrite = tbl[i].mw; aluout = tbl[i].addr;
      writedata = tbl[i].data; tx_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d valid", i), 32'(tx_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d last", i), 32'(tx_last), 32'(tbl[i].e_last));
      chk($sformatf("vec%0d hold", i), 32'(cpu_hold), 32'(tbl[i].e_hold));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d addr", i), tx_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d data", i), tx_data, tbl[i].e_data);
      tick();
    end
    chk("vec overflow", 32'(overflow), 32'd0);
    chk("vec instrs", instr_count, 32'd0);

    // ten stores into a stalled consumer
    do_reset();
    idx = 0; got = 0;
    for (int c = 0; c < 40; c++) begin
      tx_ready = (c >= 12);
      memwrite = (idx < 10);
      aluout = 32'(idx * 4);
      writedata = 32'h100 + 32'(idx);
      #1;
      if (c == 7) chk("full hold before 8th", 32'(cpu_hold), 32'd0);
      if (c == 8) chk("full hold after 8th", 32'(cpu_hold), 32'(HOLD_WHEN_FULL));
      if (tx_valid && tx_ready) begin
        chk($sformatf("full rec%0d addr", got), tx_addr, 32'(got * 4));
        chk($sformatf("full rec%0d data", got), tx_data, 32'h100 + 32'(got));
        got++;
      end
      if (memwrite && !cpu_hold) idx++;
      tick();
    end
    memwrite = 1'b0;
    #1;
    chk("full delivered", 32'(got), 32'(EXP_DELIVERED));
    chk("full overflow", 32'(overflow), 32'(EXP_OVERFLOW));
    chk("full empty after", 32'(tx_valid), 32'd0);

    // drain with a toggling consumer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      memwrite = 1'b1; aluout = 32'h40 + 32'(k * 4); writedata = 32'h200 + 32'(k);
      tick();
    end
    memwrite = 1'b0; pc = 32'h3C;
    #1;
    chk("drain finish hold", 32'(cpu_hold), 32'd1);
    tick();
    pops = 0; was_stalled = 1'b0; held = 32'h0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      tx_ready = (c % 2 == 1);
      #1;
      chk("drain hold", 32'(cpu_hold), 32'd1);
      chk("drain valid", 32'(tx_valid), 32'd1);
      chk("drain last", 32'(tx_last), 32'd0);
      if (was_stalled) chk("drain data stable", tx_data, held);
      chk("drain data order", tx_data, 32'h200 + 32'(pops));
      was_stalled = tx_valid & ~tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) pops++;
      tick();
    end
    chk("drain pops", 32'(pops), 32'd4);
    tx_ready = 1'b0;
    #1;
    chk("drain empty valid", 32'(tx_valid), 32'd0);
    chk("drain empty hold", 32'(cpu_hold), 32'd1);
    tick();
    #1;
    chk("drain end last", 32'(tx_last), 32'd1);
    chk("drain end data", tx_data, 32'd4);

    // counters: 20 retires, finish after 25 cycles
    do_reset();
    retire = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    retire = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    pc = 32'h3C;
    #1;
    chk("cnt instrs", instr_count, 32'd20);
    chk("cnt cycles", cycle_count, 32'd25);
    tick();
    tick();
    #1;
    chk("end valid", 32'(tx_valid), 32'd1);
    chk("end last", 32'(tx_last), 32'd1);
    chk("end addr", tx_addr, 32'h3C);
    chk("end data", tx_data, 32'd25);
    tick();
    #1;
    chk("end held data", tx_data, 32'd25);
    chk("end held last", 32'(tx_last), 32'd1);

    // reset while the end token is pending
    reset = 1'b0; pc = 32'h0;
    tick();
    #1;
    chk("abort valid", 32'(tx_valid), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort cycles", cycle_count, 32'd0);
    chk("abort instrs", instr_count, 32'd0);
    chk("abort hold", 32'(cpu_hold), 32'd0);
    reset = 1'b1;
    tick();
    #1;
    chk("abort running", cycle_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_trace_tx.md
STORE_TRACE_TX -- requirements
Module: store_trace_tx

Interface
REQ-001 Parameter: DEPTH, 8, number of store-trace FIFO entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: pc  input  32  CPU fetch PC.
REQ-005 Port: pc_finished  input  32  end-of-program PC; held stable while reset is high.
REQ-006 Port: memwrite  input  1  CPU data-memory write strobe.
REQ-007 Port: aluout  input  32  CPU store byte address.
REQ-008 Port: writedata  input  32  CPU store data.
REQ-009 Port: retire  input  1  one instruction entered decode this cycle (not flushed, not stalled).
REQ-010 Port: cpu_hold  output  1  freezes CPU clock enable and data-memory write enable when high.
REQ-011 Port: tx_valid  output  1  trace record available.
REQ-012 Port: tx_ready  input  1  consumer accepts the record.
REQ-013 Port: tx_addr  output  32  record address field.
REQ-014 Port: tx_data  output  32  record data field.
REQ-015 Port: tx_last  output  1  record is the end token.
REQ-016 Port: done  output  1  trace complete.
REQ-017 Port: overflow  output  1  sticky; a store was lost.
REQ-018 Port: cycle_count  output  32  cycles run before finish.
REQ-019 Port: instr_count  output  32  instructions retired.

Function
REQ-020 finish SHALL be the combinational value (pc == pc_finished).
REQ-021 FSM states: RUN, DRAIN, END, DONE; RUN -> DRAIN when finish; DRAIN -> END when FIFO empty; END -> DONE on tx_valid & tx_ready; DONE is held until reset.
REQ-022 cpu_hold SHALL be 1 whenever state != RUN, or finish is 1, or (with STALL_ON_FULL_EN) the FIFO is full.
REQ-023 Push SHALL occur when state == RUN & memwrite & ~cpu_hold; entry = {aluout, writedata}.
REQ-024 Pop SHALL occur when tx_valid & tx_ready & ~tx_last.
REQ-025 FIFO SHALL be first-word fall-through: tx_valid = ~empty in RUN/DRAIN; tx_addr/tx_data = head entry; a store pushed at edge t SHALL be visible at tx_* after edge t, not before.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 In END: tx_valid=1, tx_last=1, tx_addr=pc_finished, tx_data=cycle_count.
REQ-028 tx_addr, tx_data and tx_last SHALL stay stable while tx_valid & ~tx_ready.
REQ-029 cycle_count SHALL increment by 1 on every cycle in RUN with ~finish, including full-stall cycles; it SHALL wrap at 2^32.
REQ-030 instr_count SHALL increment when state == RUN & retire & ~cpu_hold.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 tx_ready SHALL be ignored while tx_valid is 0.

Reset
REQ-033 With reset low at a rising edge: state=RUN, FIFO empty, pointers 0, cycle_count=0, instr_count=0, overflow=0, done=0, tx_valid=0, tx_last=0, tx_addr=0, tx_data=0.
REQ-034 Reset SHALL abort any state, including DRAIN and END, and discard pending records with no end token emitted.

Configuration
REQ-035 Macro STALL_ON_FULL_EN defined: a full FIFO asserts cpu_hold, no store is ever lost, and overflow stays 0.
REQ-036 Macro STALL_ON_FULL_EN undefined: full does not assert cpu_hold; a push attempt while full and not popping is dropped and sets overflow; a push while full with a same-cycle pop is accepted.

Verification
REQ-037 Scenario: 3 stores [0x0]=0x5, [0x4]=0x7, [0x8]=0xC with tx_ready=1, then pc reaches pc_finished=0x3C -> 3 records in order, then end token tx_addr=0x3C, tx_last=1, then done=1.
REQ-038 Scenario: DEPTH=8, tx_ready=0, 10 consecutive stores, macro defined -> cpu_hold=1 after the 8th store, all 10 records delivered once tx_ready=1, overflow=0.
REQ-039 Scenario: same stimulus as REQ-038 with macro undefined -> records 1-8 delivered, records 9 and 10 lost, overflow=1.
REQ-040 Scenario: finish with 4 records queued and tx_ready toggling 1/0 -> state stays DRAIN until the 4th pop, tx_data held stable while tx_ready=0, cpu_hold=1 throughout.
REQ-041 Scenario: retire=1 for 20 cycles, finish at cycle 25 -> instr_count=20, cycle_count=25, end-token tx_data=25.
REQ-042 Scenario: reset low during END -> next cycle tx_valid=0, done=0, both counts 0, state RUN.
